// File: rtl/medidor_freq_pkg.sv
// ============================================================================
// Module : medidor_freq_pkg
// Brief  : Shared constants and state encoding for the frequency meter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package medidor_freq_pkg;

    localparam int CLOCK_HZ = 50_000_000;

    localparam logic [0:0] ARMANDO = 1'b0;
    localparam logic [0:0] MEDINDO = 1'b1;

    // One-second gate; the count then reads directly in Hz
    localparam int GATE_CYCLES_DEF = CLOCK_HZ;
    localparam int COUNT_W_DEF     = $clog2(CLOCK_HZ + 1);

    function automatic int gate_w(input int gate);
        return (gate <= 2) ? 1 : $clog2(gate);
    endfunction

endpackage

`default_nettype wire

// File: rtl/medidor_freq_if.sv
// ============================================================================
// Module : medidor_freq_if
// Brief  : Measured input and published result of the frequency meter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface medidor_freq_if
    import medidor_freq_pkg::*;
#(
    parameter int COUNT_W = COUNT_W_DEF
);
    logic               sinal_in;
    logic [COUNT_W-1:0] freq_out;
    logic               valid_out;
    logic               overflow_out;

    modport master (
        output sinal_in,
        input  freq_out,
        input  valid_out,
        input  overflow_out
    );

    modport slave (
        input  sinal_in,
        output freq_out,
        output valid_out,
        output overflow_out
    );
endinterface

`default_nettype wire

// File: rtl/detector_borda.sv
// ============================================================================
// Module : detector_borda
// Brief  : Two-flop synchronizer plus registered one-cycle rising-edge pulse.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module detector_borda (
    input  wire logic clock_in,
    input  wire logic reset,
    input  wire logic sinal_in,
    output logic      borda_out
);
    logic r_sync1;
    logic r_sync2;
    logic r_prev;
    logic r_borda;

    always_ff @(posedge clock_in) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
            r_borda <= 1'b0;
        end else begin
            r_sync1 <= sinal_in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_borda <= r_sync2 & ~r_prev;
        end
    end

    assign borda_out = r_borda;

endmodule

`default_nettype wire

// File: rtl/medidor_freq.sv
// ============================================================================
// Module : medidor_freq
// Brief  : Counts input rising edges per gate window and publishes the count.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module medidor_freq
    import medidor_freq_pkg::*;
#(
    parameter int GATE_CYCLES = GATE_CYCLES_DEF,
    parameter int COUNT_W     = COUNT_W_DEF
) (
    input  wire logic       clock_in,
    input  wire logic       reset,
    medidor_freq_if.slave   bus
);
    localparam int              G_W    = gate_w(GATE_CYCLES);
    localparam logic [G_W-1:0]  G_LAST = G_W'(GATE_CYCLES - 1);

    logic               w_borda;
    logic               w_terminal;
    logic [COUNT_W-1:0] w_final;
    logic               w_flag_final;

    logic [G_W-1:0]     r_gate;
    logic [COUNT_W-1:0] r_count;
    logic               r_flag;
    logic [0:0]         r_state;
    logic [COUNT_W-1:0] r_freq;
    logic               r_valid;
    logic               r_ovf;

    detector_borda u_detector (
        .clock_in  (clock_in),
        .reset     (reset),
        .sinal_in  (bus.sinal_in),
        .borda_out (w_borda)
    );

    // Saturating next count; also the window total on the terminal cycle
    always_comb begin
        w_terminal   = (r_gate == G_LAST);
        w_final      = r_count;
        w_flag_final = r_flag;
        if (w_borda) begin
            if (&r_count) begin
                w_flag_final = 1'b1;
            end else begin
                w_final = r_count + COUNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            r_gate  <= '0;
            r_count <= '0;
            r_flag  <= 1'b0;
            r_state <= ARMANDO;
            r_freq  <= '0;
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (w_terminal) begin
                r_gate  <= '0;
                r_count <= '0;
                r_flag  <= 1'b0;
                r_state <= MEDINDO;
                // The first window after reset may hold a synchronizer artefact
                if (r_state == MEDINDO) begin
                    r_freq  <= w_final;
                    r_ovf   <= w_flag_final;
                    r_valid <= 1'b1;
                end
            end else begin
                r_gate  <= r_gate + G_W'(1);
                r_count <= w_final;
                r_flag  <= w_flag_final;
            end
        end
    end

    assign bus.freq_out     = r_freq;
    assign bus.valid_out    = r_valid;
    assign bus.overflow_out = r_ovf;

endmodule

`default_nettype wire
